// File: rtl/fifo_occupancy_monitor.sv
// ---------------------------------------------------------------------------
// fifo_occupancy_monitor
//
// Tracks the occupancy of the five transaction-layer FIFOs (main, VC0, VC1,
// D0, D1) from their push/pop strobes. It returns the registered status
// vectors that the control FSM samples: non-empty, sticky errors, almost
// empty/full against the FSM-supplied thresholds, and full.
//
// Vector bit ordering everywhere: 0 main, 1 VC0, 2 VC1, 3 D0, 4 D1.
//
// Parameters:
//   DEPTH  entries per FIFO (must be <= 31)
//   CW     occupancy counter width
//
// Ports:
//   clk            clock
//   reset          synchronous, active-low reset
//   push, pop      per-FIFO write / read strobes
//   mf_l .. d1_h   per-FIFO low / high thresholds (level inputs)
//   err_clr        per-FIFO sticky error clear (OCC_ERR_CLEAR_EN only)
//   empties        1 when that FIFO holds at least one entry
//   errors         sticky overflow/underflow flag
//   almost_empty   occupancy <= low threshold
//   almost_full    occupancy >= high threshold (high threshold 0 disables)
//   full           occupancy == DEPTH
//   occ            packed occupancy, FIFO i at [CW*i +: CW]
//
// Optional feature macro: OCC_ERR_CLEAR_EN (adds err_clr).
// ---------------------------------------------------------------------------
module fifo_occupancy_monitor #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    push,
    input  logic [4:0]    pop,
    input  logic [CW-1:0] mf_l,
    input  logic [CW-1:0] mf_h,
    input  logic [CW-1:0] vco_l,
    input  logic [CW-1:0] vco_h,
    input  logic [CW-1:0] vc1_l,
    input  logic [CW-1:0] vc1_h,
    input  logic [CW-1:0] do_l,
    input  logic [CW-1:0] do_h,
    input  logic [CW-1:0] d1_l,
    input  logic [CW-1:0] d1_h,
`ifdef OCC_ERR_CLEAR_EN
    input  logic [4:0]    err_clr,
`endif
    output logic [4:0]    empties,
    output logic [4:0]    errors,
    output logic [4:0]    almost_empty,
    output logic [4:0]    almost_full,
    output logic [4:0]    full,
    output logic [5*CW-1:0] occ
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] occ_q   [5];
    logic [CW-1:0] occ_nxt [5];
    logic [CW-1:0] lo_th   [5];
    logic [CW-1:0] hi_th   [5];
    logic [4:0]    err_set;
    logic [4:0]    err_nxt;
    logic [4:0]    ne_nxt;
    logic [4:0]    ae_nxt;
    logic [4:0]    af_nxt;
    logic [4:0]    full_nxt;

    always_comb begin
        lo_th[0] = mf_l;   hi_th[0] = mf_h;
        lo_th[1] = vco_l;  hi_th[1] = vco_h;
        lo_th[2] = vc1_l;  hi_th[2] = vc1_h;
        lo_th[3] = do_l;   hi_th[3] = do_h;
        lo_th[4] = d1_l;   hi_th[4] = d1_h;
    end

    // Next-state occupancy and error events; push+pop together is a
    // pass-through even at the empty/full boundaries.
    always_comb begin
        err_set = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            occ_nxt[i] = occ_q[i];
            if (push[i] && pop[i]) begin
                occ_nxt[i] = occ_q[i];
            end else if (push[i]) begin
                if (occ_q[i] == DEPTH_C) err_set[i] = 1'b1;
                else                     occ_nxt[i] = occ_q[i] + 1'b1;
            end else if (pop[i]) begin
                if (occ_q[i] == '0) err_set[i] = 1'b1;
                else                occ_nxt[i] = occ_q[i] - 1'b1;
            end
        end
    end

    // A new error event in the same cycle as a clear keeps the bit set.
    always_comb begin
`ifdef OCC_ERR_CLEAR_EN
        err_nxt = (errors & ~err_clr) | err_set;
`else
        err_nxt = errors | err_set;
`endif
    end

    // Flags are derived from the next-state occupancy so they line up with
    // the registered occ values.
    always_comb begin
        ne_nxt   = '0;
        ae_nxt   = '0;
        af_nxt   = '0;
        full_nxt = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            ne_nxt[i]   = (occ_nxt[i] != '0);
            full_nxt[i] = (occ_nxt[i] == DEPTH_C);
            ae_nxt[i]   = (occ_nxt[i] <= lo_th[i]);
            af_nxt[i]   = (hi_th[i] != '0) && (occ_nxt[i] >= hi_th[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 5; i++) occ_q[i] <= '0;
            empties      <= '0;
            errors       <= '0;
            almost_empty <= '1;
            almost_full  <= '0;
            full         <= '0;
        end else begin
            for (int unsigned i = 0; i < 5; i++) occ_q[i] <= occ_nxt[i];
            empties      <= ne_nxt;
            errors       <= err_nxt;
            almost_empty <= ae_nxt;
            almost_full  <= af_nxt;
            full         <= full_nxt;
        end
    end

    always_comb begin
        occ = '0;
        for (int unsigned i = 0; i < 5; i++) occ[CW*i +: CW] = occ_q[i];
    end

endmodule

// File: tb/tb_fifo_occupancy_monitor.sv
module tb_fifo_occupancy_monitor;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  push, pop;
    logic [4:0]  lo [5];
    logic [4:0]  hi [5];
    logic [4:0]  clr_v;
    logic [4:0]  empties, errors, almost_empty, almost_full, full;
    logic [24:0] occ;
    logic [49:0] got_vec;

    int          m_occ [5];
    logic [4:0]  m_err;
    logic [49:0] exp_q [$];
    logic [49:0] e;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    assign got_vec = {empties, errors, almost_empty, almost_full, full, occ};

    fifo_occupancy_monitor #(.DEPTH(DEPTH), .CW(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .mf_l         (lo[0]),
        .mf_h         (hi[0]),
        .vco_l        (lo[1]),
        .vco_h        (hi[1]),
        .vc1_l        (lo[2]),
        .vc1_h        (hi[2]),
        .do_l         (lo[3]),
        .do_h         (hi[3]),
        .d1_l         (lo[4]),
        .d1_h         (hi[4]),
`ifdef OCC_ERR_CLEAR_EN
        .err_clr      (clr_v),
`endif
        .empties      (empties),
        .errors       (errors),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .full         (full),
        .occ          (occ)
    );

    // Expected {empties, errors, almost_empty, almost_full, full, occ}
    function automatic logic [49:0] model_vec(input logic rst_n);
        logic [4:0]  ne, ae, af, fu;
        logic [24:0] o;
        ne = '0; ae = '0; af = '0; fu = '0; o = '0;
        if (!rst_n) return {5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 25'h0};
        for (int i = 0; i < 5; i++) begin
            ne[i] = (m_occ[i] != 0);
            fu[i] = (m_occ[i] == DEPTH);
            ae[i] = (m_occ[i] <= int'(lo[i]));
            af[i] = (hi[i] != 5'd0) && (m_occ[i] >= int'(hi[i]));
            o[5*i +: 5] = 5'(m_occ[i]);
        end
        return {ne, m_err, ae, af, fu, o};
    endfunction

    // Drive one cycle of stimulus, advance the model, queue the expectation.
    task automatic step(input logic [4:0] pu, input logic [4:0] po, input logic rst_n);
        logic [4:0] set;
        @(negedge clk);
        push = pu; pop = po; reset = rst_n;
        set = '0;
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) m_occ[i] = 0;
            m_err = '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                case ({pu[i], po[i]})
                    2'b10: if (m_occ[i] >= DEPTH) set[i] = 1'b1; else m_occ[i]++;
                    2'b01: if (m_occ[i] == 0) set[i] = 1'b1; else m_occ[i]--;
                    default: ;
                endcase
            end
`ifdef OCC_ERR_CLEAR_EN
            m_err = (m_err & ~clr_v) | set;
`else
            m_err = m_err | set;
`endif
        end
        exp_q.push_back(model_vec(rst_n));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin lo[i] = 5'd0; hi[i] = 5'd0; end
        step(5'h00, 5'h00, 1'b0);
        step(5'h1F, 5'h00, 1'b0);
        for (int n = 0; n < 3; n++) begin
            if (n == 2) step(5'h00, 5'h00, 1'b1);
            e = exp_q.pop_front(); vectors++;
            if (n < 2) continue;
            if (got_vec !== e) begin
                miscompares++;
                $display("FAIL reset_sb got=%h exp=%h", got_vec, e);
            end
        end
        vectors++;
        if ({empties, errors, almost_empty, almost_full, full, occ} !== {5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 25'h0}) begin
            miscompares++;
            $display("FAIL reset_values got=%h exp=%h", got_vec, {5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 25'h0});
        end
    endtask

    task automatic test_main_thresholds();
        lo[0] = 5'd2; hi[0] = 5'd12;
        for (int n = 1; n <= 12; n++) begin
            step(5'h01, 5'h00, 1'b1);
            e = exp_q.pop_front(); vectors++;
            if (got_vec !== e) begin
                miscompares++;
                $display("FAIL main_push%0d got=%h exp=%h", n, got_vec, e);
            end
            vectors++;
            if (almost_empty[0] !== (n <= 2)) begin
                miscompares++;
                $display("FAIL main_ae push%0d got=%b exp=%b", n, almost_empty[0], (n <= 2));
            end
            vectors++;
            if (almost_full[0] !== (n >= 12)) begin
                miscompares++;
                $display("FAIL main_af push%0d got=%b exp=%b", n, almost_full[0], (n >= 12));
            end
        end
        vectors++;
        if (empties !== 5'h01 || occ[4:0] !== 5'd12) begin
            miscompares++;
            $display("FAIL main_final empties=%h occ0=%0d exp empties=01 occ0=12", empties, occ[4:0]);
        end
    endtask

    task automatic test_overflow();
        for (int n = 1; n <= 17; n++) begin
            step(5'h04, 5'h00, 1'b1);
            e = exp_q.pop_front(); vectors++;
            if (got_vec !== e) begin
                miscompares++;
                $display("FAIL vc1_push%0d got=%h exp=%h", n, got_vec, e);
            end
        end
        vectors++;
        if (full[2] !== 1'b1 || errors !== 5'h04 || occ[14:10] !== 5'd16) begin
            miscompares++;
            $display("FAIL vc1_overflow full2=%b errors=%h occ2=%0d exp 1/04/16", full[2], errors, occ[14:10]);
        end
        step(5'h04, 5'h04, 1'b1);
        e = exp_q.pop_front(); vectors++;
        if (got_vec !== e || occ[14:10] !== 5'd16 || errors !== 5'h04) begin
            miscompares++;
            $display("FAIL vc1_passthru got=%h exp=%h", got_vec, e);
        end
    endtask

    task automatic test_underflow();
        step(5'h00, 5'h00, 1'b0);
        void'(exp_q.pop_front());
        step(5'h00, 5'h10, 1'b1);
        e = exp_q.pop_front(); vectors++;
        if (got_vec !== e || errors !== 5'h10 || occ[24:20] !== 5'd0) begin
            miscompares++;
            $display("FAIL d1_underflow got=%h exp=%h errors=%h", got_vec, e, errors);
        end
        step(5'h10, 5'h00, 1'b1);
        e = exp_q.pop_front(); vectors++;
        if (got_vec !== e || occ[24:20] !== 5'd1 || empties !== 5'h10 || errors[4] !== 1'b1) begin
            miscompares++;
            $display("FAIL d1_push got=%h exp=%h", got_vec, e);
        end
    endtask

    task automatic test_all_push_thresh();
        step(5'h00, 5'h00, 1'b0);
        void'(exp_q.pop_front());
        for (int n = 1; n <= 4; n++) begin
            step(5'h1F, 5'h00, 1'b1);
            e = exp_q.pop_front(); vectors++;
            if (got_vec !== e) begin
                miscompares++;
                $display("FAIL all_push%0d got=%h exp=%h", n, got_vec, e);
            end
        end
        hi[1] = 5'd3;
        step(5'h00, 5'h00, 1'b1);
        e = exp_q.pop_front(); vectors++;
        if (got_vec !== e || almost_full !== 5'h02) begin
            miscompares++;
            $display("FAIL vco_h_change almost_full=%h exp=02 vec=%h exp=%h", almost_full, got_vec, e);
        end
        step(5'h1F, 5'h00, 1'b1);
        void'(exp_q.pop_front());
        step(5'h1F, 5'h00, 1'b0);
        e = exp_q.pop_front(); vectors++;
        if (got_vec !== e || got_vec !== {5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 25'h0}) begin
            miscompares++;
            $display("FAIL midstream_reset got=%h exp=%h", got_vec, e);
        end
    endtask

`ifdef OCC_ERR_CLEAR_EN
    task automatic test_err_clear();
        step(5'h00, 5'h00, 1'b0);
        void'(exp_q.pop_front());
        for (int n = 0; n < 17; n++) begin
            step(5'h04, 5'h00, 1'b1);
            void'(exp_q.pop_front());
        end
        vectors++;
        if (errors !== 5'h04) begin
            miscompares++;
            $display("FAIL errclr_setup errors=%h exp=04", errors);
        end
        clr_v = 5'h04;
        step(5'h00, 5'h00, 1'b1);
        e = exp_q.pop_front(); vectors++;
        if (got_vec !== e || errors !== 5'h00) begin
            miscompares++;
            $display("FAIL errclr_clear errors=%h exp=00", errors);
        end
        step(5'h04, 5'h00, 1'b1);
        e = exp_q.pop_front(); vectors++;
        if (got_vec !== e || errors !== 5'h04) begin
            miscompares++;
            $display("FAIL errclr_set_wins errors=%h exp=04", errors);
        end
        clr_v = 5'h00;
    endtask
`endif

    task automatic test_random();
        step(5'h00, 5'h00, 1'b0);
        void'(exp_q.pop_front());
        for (int n = 0; n < 300; n++) begin
            if (n % 25 == 0) begin
                for (int i = 0; i < 5; i++) begin
                    lo[i] = 5'($urandom_range(0, 20));
                    hi[i] = 5'($urandom_range(0, 20));
                end
            end
            step(5'($urandom), 5'($urandom & $urandom), 1'b1);
            e = exp_q.pop_front(); vectors++;
            if (got_vec !== e) begin
                miscompares++;
                $display("FAIL random%0d got=%h exp=%h", n, got_vec, e);
            end
        end
    endtask

    initial begin
        reset = 1'b0; push = '0; pop = '0; clr_v = '0; m_err = '0;
        for (int i = 0; i < 5; i++) begin m_occ[i] = 0; lo[i] = '0; hi[i] = '0; end
        test_reset();
        test_main_thresholds();
        test_overflow();
        test_underflow();
        test_all_push_thresh();
`ifdef OCC_ERR_CLEAR_EN
        test_err_clear();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
